// File: rtl/gshare_pkg.sv
// Shared types and helpers for the gshare branch direction predictor.
// Holds the default table geometry, the counter type, FSM states and the index hash.
package gshare_pkg;

    localparam int GH_BITS_DEF  = 8;
    localparam int CTR_BITS_DEF = 2;

    typedef logic [CTR_BITS_DEF-1:0] ctr_t;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } gs_state_e;

    // Callers keep only the low GH_BITS of the result as the table index.
    function automatic logic [31:0] gs_hash(input logic [31:0] h,
                                            input logic [31:0] pc,
                                            input int          pc_lsb);
        return h ^ (pc >> pc_lsb);
    endfunction

endpackage

// File: rtl/gshare_2bc_predictor_if.sv
// Fetch-side lookup and resolution-side update bundle for the gshare predictor.
// The master modport belongs to fetch/branch queue; the slave modport belongs to the predictor.
interface gshare_2bc_predictor_if
    import gshare_pkg::*;
#(
    parameter int GH_BITS = GH_BITS_DEF
);

    logic               pred_req;
    logic [31:0]        pred_pc;
    logic               pred_valid;
    logic               pred_taken;
    logic [GH_BITS-1:0] pred_gh;
    logic               upd_valid;
    logic [31:0]        upd_pc;
    logic [GH_BITS-1:0] upd_gh;
    logic               upd_taken;
    logic               upd_mispredict;
    logic               busy;

    modport master (
        output pred_req, pred_pc, upd_valid, upd_pc, upd_gh, upd_taken, upd_mispredict,
        input  pred_valid, pred_taken, pred_gh, busy
    );

    modport slave (
        input  pred_req, pred_pc, upd_valid, upd_pc, upd_gh, upd_taken, upd_mispredict,
        output pred_valid, pred_taken, pred_gh, busy
    );

endinterface

// File: rtl/bp_sat_ctr.sv
// Combinational saturating up/down counter step for branch predictor tables.
// Counts up on taken, down on not-taken, holding at all-ones and zero.
module bp_sat_ctr #(
    parameter int CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_i,
    input  logic                taken_i,
    output logic [CTR_BITS-1:0] ctr_o
);

    // NOTE: the output is assigned first so every path drives it and no latch is inferred.
    always_comb begin
        ctr_o = ctr_i;
        if (taken_i) begin
            if (ctr_i != '1) ctr_o = ctr_i + CTR_BITS'(1);
        end else begin
            if (ctr_i != '0) ctr_o = ctr_i - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/gshare_2bc_predictor.sv
// Gshare direction predictor: counter table indexed by (speculative history ^ PC bits).
// Define GSHARE_PRED_REG_EN to register pred_valid/pred_taken/pred_gh (one-cycle latency).
module gshare_2bc_predictor
    import gshare_pkg::*;
#(
    parameter int GH_BITS  = GH_BITS_DEF,
    parameter int PC_LSB   = 2,
    parameter int CTR_BITS = CTR_BITS_DEF,
    parameter int INIT_CTR = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    gshare_2bc_predictor_if.slave  bp
);

    localparam int ENTRIES = 2**GH_BITS;

    typedef logic [GH_BITS-1:0]  idx_t;
    typedef logic [CTR_BITS-1:0] cnt_t;

    gs_state_e state_q, state_d;
    idx_t      init_idx_q, init_idx_d;
    idx_t      ghr_q, ghr_d;
    cnt_t      table_q [ENTRIES];

    logic is_run;
    logic repair;
    logic pred_fire;
    logic pred_taken_c;
    idx_t pred_idx;
    idx_t upd_idx;
    cnt_t upd_ctr_cur;
    cnt_t upd_ctr_nxt;
    logic wr_en;
    idx_t wr_idx;
    cnt_t wr_data;

    assign is_run    = (state_q == RUN);
    assign repair    = is_run & bp.upd_valid & bp.upd_mispredict;
    // A repair redirects fetch, so a same-cycle lookup is dropped.
    assign pred_fire = is_run & ~reset & bp.pred_req & ~repair;

    assign pred_idx = idx_t'(gs_hash(32'(ghr_q), bp.pred_pc, PC_LSB));
    assign upd_idx  = idx_t'(gs_hash(32'(bp.upd_gh), bp.upd_pc, PC_LSB));

    // Reads see the pre-write contents; a same-cycle train is visible next cycle.
    assign pred_taken_c = table_q[pred_idx][CTR_BITS-1];
    assign upd_ctr_cur  = table_q[upd_idx];

    bp_sat_ctr #(
        .CTR_BITS (CTR_BITS)
    ) u_upd_ctr (
        .ctr_i   (upd_ctr_cur),
        .taken_i (bp.upd_taken),
        .ctr_o   (upd_ctr_nxt)
    );

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        ghr_d      = ghr_q;
        wr_en      = 1'b0;
        wr_idx     = init_idx_q;
        wr_data    = cnt_t'(INIT_CTR);
        case (state_q)
            INIT: begin
                wr_en      = 1'b1;
                init_idx_d = init_idx_q + idx_t'(1);
                if (init_idx_q == idx_t'(ENTRIES - 1)) state_d = RUN;
            end
            RUN: begin
                if (bp.upd_valid) begin
                    wr_en   = 1'b1;
                    wr_idx  = upd_idx;
                    wr_data = upd_ctr_nxt;
                end
                if (repair) begin
                    ghr_d = {bp.upd_gh[GH_BITS-2:0], bp.upd_taken};
                end else if (pred_fire) begin
                    ghr_d = {ghr_q[GH_BITS-2:0], pred_taken_c};
                end
            end
            default: state_d = INIT;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= INIT;
            init_idx_q <= '0;
            ghr_q      <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ghr_q      <= ghr_d;
        end
    end

    // NOTE: the table has no reset; the INIT sweep writes every entry through the single write port.
    always_ff @(posedge clock) begin
        if (wr_en) table_q[wr_idx] <= wr_data;
    end

`ifdef GSHARE_PRED_REG_EN
    logic pred_valid_q, pred_valid_d;
    logic pred_taken_q, pred_taken_d;
    idx_t pred_gh_q,    pred_gh_d;

    always_comb begin
        pred_valid_d = pred_fire;
        pred_taken_d = pred_fire & pred_taken_c;
        pred_gh_d    = pred_fire ? ghr_q : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_gh_q    <= '0;
        end else begin
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_gh_q    <= pred_gh_d;
        end
    end

    assign bp.pred_valid = pred_valid_q;
    assign bp.pred_taken = pred_taken_q;
    assign bp.pred_gh    = pred_gh_q;
`else
    assign bp.pred_valid = pred_fire;
    assign bp.pred_taken = pred_fire & pred_taken_c;
    assign bp.pred_gh    = pred_fire ? ghr_q : '0;
`endif

    assign bp.busy = ~is_run;

endmodule

// File: tb/tb_gshare_2bc_predictor.sv
// Self-checking bench for gshare_2bc_predictor (GH_BITS=4, CTR_BITS=2, INIT_CTR=1).
// A table-of-integers reference model predicts every lookup; spec scenarios are also checked against constants.
module tb_gshare_2bc_predictor;

    localparam int GH = 4;
    localparam int N  = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    gshare_2bc_predictor_if #(.GH_BITS(GH)) bp ();

    gshare_2bc_predictor #(
        .GH_BITS  (GH),
        .PC_LSB   (2),
        .CTR_BITS (2),
        .INIT_CTR (1)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bp    (bp)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: counter values as plain integers 0..3 and history as an integer 0..15.
    int m_ctr [N];
    int m_ghr;

    task automatic drive_idle();
        bp.pred_req       = 1'b0;
        bp.pred_pc        = '0;
        bp.upd_valid      = 1'b0;
        bp.upd_pc         = '0;
        bp.upd_gh         = '0;
        bp.upd_taken      = 1'b0;
        bp.upd_mispredict = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) m_ctr[i] = 1;
        m_ghr = 0;
    endtask

    function automatic int slot(input int h, input logic [31:0] pc);
        return (h ^ int'(pc / 4)) % N;
    endfunction

    task automatic model_step(input bit req, input logic [31:0] pc, input bit uv,
                              input logic [31:0] upc, input int ugh, input bit ut, input bit um,
                              output bit ev, output bit et, output int egh);
        int  pi;
        int  ui;
        bit  redirect;
        redirect = uv && um;
        pi  = slot(m_ghr, pc);
        ev  = req && !redirect;
        et  = (m_ctr[pi] >= 2);
        egh = m_ghr;
        if (uv) begin
            ui = slot(ugh, upc);
            if (ut) m_ctr[ui] = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
            else    m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
        if (redirect)  m_ghr = (ugh * 2 + int'(ut)) % N;
        else if (ev)   m_ghr = (m_ghr * 2 + int'(et)) % N;
    endtask

    // One operating cycle: drive after a falling edge, sample where this build presents the result.
    task automatic dut_step(input bit req, input logic [31:0] pc, input bit uv,
                            input logic [31:0] upc, input int ugh, input bit ut, input bit um,
                            output bit ov, output bit ot, output int ogh);
        @(negedge clock);
        bp.pred_req       = req;
        bp.pred_pc        = pc;
        bp.upd_valid      = uv;
        bp.upd_pc         = upc;
        bp.upd_gh         = 4'(ugh);
        bp.upd_taken      = ut;
        bp.upd_mispredict = um;
`ifdef GSHARE_PRED_REG_EN
        @(posedge clock);
        #1;
        ov  = bp.pred_valid;
        ot  = bp.pred_taken;
        ogh = int'(bp.pred_gh);
`else
        #2;
        ov  = bp.pred_valid;
        ot  = bp.pred_taken;
        ogh = int'(bp.pred_gh);
        @(posedge clock);
        #1;
`endif
        drive_idle();
    endtask

    task automatic step_both(input bit req, input logic [31:0] pc, input bit uv,
                             input logic [31:0] upc, input int ugh, input bit ut, input bit um,
                             output bit ov, output bit ot, output int ogh,
                             output bit ev, output bit et, output int egh);
        model_step(req, pc, uv, upc, ugh, ut, um, ev, et, egh);
        dut_step(req, pc, uv, upc, ugh, ut, um, ov, ot, ogh);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive_idle();
        @(posedge clock);
        #1;
        n_checks++;
        if (bp.busy !== 1'b1 || bp.pred_valid !== 1'b0 || bp.pred_taken !== 1'b0 || bp.pred_gh !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b valid=%b taken=%b gh=%h, required busy=1 valid=0 taken=0 gh=0",
                     bp.busy, bp.pred_valid, bp.pred_taken, bp.pred_gh);
        end
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Counts busy cycles while hammering the ignored inputs; returns at the first idle falling edge.
    task automatic wait_init(output int busy_cycles);
        busy_cycles = 0;
        for (int k = 0; k < 100; k++) begin
            if (bp.busy !== 1'b1) break;
            busy_cycles++;
            bp.pred_req       = 1'b1;
            bp.pred_pc        = $urandom;
            bp.upd_valid      = 1'b1;
            bp.upd_pc         = $urandom;
            bp.upd_gh         = 4'($urandom);
            bp.upd_taken      = 1'($urandom);
            bp.upd_mispredict = 1'b1;
            #2;
            n_checks++;
            if (bp.pred_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL init_pred_valid: pred_valid=%b during INIT, required 0", bp.pred_valid);
            end
            @(negedge clock);
        end
        drive_idle();
    endtask

    task automatic test_reset();
        int cycles;
        do_reset();
        wait_init(cycles);
        n_checks++;
        if (cycles !== 16) begin
            n_fail++;
            $display("FAIL init_length: busy for %0d cycles, required 16", cycles);
        end
        model_reset();
    endtask

    task automatic test_basic_predict();
        bit ov, ot, ev, et;
        int ogh, egh;
        for (int r = 0; r < 2; r++) begin
            step_both(1, 32'h10, 0, 0, 0, 0, 0, ov, ot, ogh, ev, et, egh);
            n_checks++;
            if (ov !== 1'b1 || ot !== 1'b0 || ogh !== 0) begin
                n_fail++;
                $display("FAIL basic_predict_%0d: valid=%b taken=%b gh=%h, required valid=1 taken=0 gh=0",
                         r, ov, ot, ogh);
            end
        end
    endtask

    task automatic test_saturation();
        bit ov, ot, ev, et;
        int ogh, egh;
        for (int r = 0; r < 3; r++) step_both(0, 0, 1, 32'h10, 0, 1, 0, ov, ot, ogh, ev, et, egh);
        step_both(1, 32'h10, 0, 0, 0, 0, 0, ov, ot, ogh, ev, et, egh);
        n_checks++;
        if (ov !== 1'b1 || ot !== 1'b1 || ogh !== 0) begin
            n_fail++;
            $display("FAIL saturate_up: valid=%b taken=%b gh=%h, required valid=1 taken=1 gh=0", ov, ot, ogh);
        end
        // One more taken then one not-taken: a saturating counter stays in the taken half.
        step_both(0, 0, 1, 32'h10, 0, 1, 0, ov, ot, ogh, ev, et, egh);
        step_both(0, 0, 1, 32'h10, 0, 0, 0, ov, ot, ogh, ev, et, egh);
        step_both(1, 32'h14, 0, 0, 0, 0, 0, ov, ot, ogh, ev, et, egh);
        n_checks++;
        if (ov !== 1'b1 || ot !== 1'b1 || ogh !== 1) begin
            n_fail++;
            $display("FAIL saturate_hold: valid=%b taken=%b gh=%h, required valid=1 taken=1 gh=1", ov, ot, ogh);
        end
    endtask

    task automatic test_repair();
        bit ov, ot, ev, et;
        int ogh, egh;
        step_both(0, 0, 1, 32'h0, 4'b0101, 1, 1, ov, ot, ogh, ev, et, egh);
        step_both(1, 32'h40, 1, 32'h0, 4'b0110, 1, 1, ov, ot, ogh, ev, et, egh);
        n_checks++;
        if (ov !== 1'b0) begin
            n_fail++;
            $display("FAIL repair_drop: pred_valid=%b alongside mispredict, required 0", ov);
        end
        step_both(1, 32'h0, 0, 0, 0, 0, 0, ov, ot, ogh, ev, et, egh);
        n_checks++;
        if (ov !== 1'b1 || ogh !== 4'b1101 || ot !== 1'b0) begin
            n_fail++;
            $display("FAIL repair_ghr: valid=%b gh=%h taken=%b, required valid=1 gh=d taken=0", ov, ogh, ot);
        end
        // Correct-path update must not disturb history: ghr is now 1010.
        step_both(0, 0, 1, 32'h0, 4'b0011, 0, 0, ov, ot, ogh, ev, et, egh);
        step_both(1, 32'h0, 0, 0, 0, 0, 0, ov, ot, ogh, ev, et, egh);
        n_checks++;
        if (ov !== 1'b1 || ogh !== 4'b1010) begin
            n_fail++;
            $display("FAIL correct_update_ghr: valid=%b gh=%h, required valid=1 gh=a", ov, ogh);
        end
    endtask

    task automatic test_same_cycle();
        bit ov, ot, ev, et;
        int ogh, egh;
        int cycles;
        do_reset();
        wait_init(cycles);
        n_checks++;
        if (cycles !== 16) begin
            n_fail++;
            $display("FAIL reinit_length: busy for %0d cycles, required 16", cycles);
        end
        model_reset();
        step_both(1, 32'h10, 1, 32'h10, 0, 1, 0, ov, ot, ogh, ev, et, egh);
        n_checks++;
        if (ov !== 1'b1 || ot !== 1'b0 || ogh !== 0) begin
            n_fail++;
            $display("FAIL same_cycle_old: valid=%b taken=%b gh=%h, required valid=1 taken=0 gh=0", ov, ot, ogh);
        end
        step_both(1, 32'h10, 0, 0, 0, 0, 0, ov, ot, ogh, ev, et, egh);
        n_checks++;
        if (ov !== 1'b1 || ot !== 1'b1 || ogh !== 0) begin
            n_fail++;
            $display("FAIL same_cycle_new: valid=%b taken=%b gh=%h, required valid=1 taken=1 gh=0", ov, ot, ogh);
        end
    endtask

    task automatic test_reset_mid_init();
        int cycles;
        do_reset();
        for (int k = 0; k < 8; k++) @(negedge clock);
        n_checks++;
        if (bp.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_init_busy: busy=%b, required 1", bp.busy);
        end
        do_reset();
        wait_init(cycles);
        n_checks++;
        if (cycles !== 16) begin
            n_fail++;
            $display("FAIL mid_init_restart: busy for %0d cycles after re-reset, required 16", cycles);
        end
        model_reset();
    endtask

    task automatic test_random();
        bit ov, ot, ev, et;
        int ogh, egh;
        bit req, uv, ut, um;
        logic [31:0] pc, upc;
        int ugh;
        for (int i = 0; i < 400; i++) begin
            req = ($urandom_range(3) != 0);
            uv  = 1'($urandom);
            ut  = 1'($urandom);
            um  = ($urandom_range(5) == 0);
            pc  = (i % 2 == 0) ? ($urandom & 32'h3C) : $urandom;
            upc = (i % 3 == 0) ? pc : ($urandom & 32'h7C);
            ugh = $urandom_range(N - 1);
            step_both(req, pc, uv, upc, ugh, ut, um, ov, ot, ogh, ev, et, egh);
            n_checks++;
            if (ov !== ev || (ev && (ot !== et || ogh !== egh))) begin
                n_fail++;
                $display("FAIL random_%0d: valid=%b taken=%b gh=%h, required valid=%b taken=%b gh=%h",
                         i, ov, ot, ogh, ev, et, egh);
            end
        end
    endtask

    initial begin
        drive_idle();
        test_reset();
        test_basic_predict();
        test_saturation();
        test_repair();
        test_same_cycle();
        test_random();
        test_reset_mid_init();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
